// File: rtl/layer_compositor_if.sv
// Pixel-side bundle of the layer compositor: scan position, layer geometry,
// ROM data going in, and composed pixel, syncs and ROM offsets coming out.
interface layer_compositor_if #(
   parameter int NUM_LAYERS = 4,
   parameter int COORD_W    = 10,
   parameter int COLOR_W    = 8,
   parameter int SCROLL_W   = 6
);
   logic [COORD_W-1:0]              DrawX;
   logic [COORD_W-1:0]              DrawY;
   logic                            blank;
   logic                            hs_in;
   logic                            vs_in;
   logic [NUM_LAYERS-1:0]           layer_en;
   logic [NUM_LAYERS*COORD_W-1:0]   layer_x;
   logic [NUM_LAYERS*COORD_W-1:0]   layer_y;
   logic [NUM_LAYERS*COORD_W-1:0]   layer_w;
   logic [NUM_LAYERS*COORD_W-1:0]   layer_h;
   logic [NUM_LAYERS*SCROLL_W-1:0]  layer_scroll;
   logic [NUM_LAYERS*COORD_W-1:0]   ofs_x;
   logic [NUM_LAYERS*COORD_W-1:0]   ofs_y;
   logic [NUM_LAYERS*3*COLOR_W-1:0] sprite_rgb;
   logic [3*COLOR_W-1:0]            bg_rgb;
   logic [COLOR_W-1:0]              Red;
   logic [COLOR_W-1:0]              Green;
   logic [COLOR_W-1:0]              Blue;
   logic                            blank_out;
   logic                            hs_out;
   logic                            vs_out;
   logic [NUM_LAYERS-1:0]           hit_mask;
   logic                            frame_collision;

   modport master (
      output DrawX, DrawY, blank, hs_in, vs_in, layer_en, layer_x, layer_y,
             layer_w, layer_h, layer_scroll, sprite_rgb, bg_rgb,
      input  ofs_x, ofs_y, Red, Green, Blue, blank_out, hs_out, vs_out,
             hit_mask, frame_collision
   );

   modport slave (
      input  DrawX, DrawY, blank, hs_in, vs_in, layer_en, layer_x, layer_y,
             layer_w, layer_h, layer_scroll, sprite_rgb, bg_rgb,
      output ofs_x, ofs_y, Red, Green, Blue, blank_out, hs_out, vs_out,
             hit_mask, frame_collision
   );
endinterface

// File: rtl/layer_compositor.sv
// Pipelined sprite-layer compositor: hit test, ROM-latency alignment, colour-key
// priority mux, delayed syncs and a per-frame layer-0 collision flag.
module layer_compositor #(
   parameter int                     NUM_LAYERS = 4,
   parameter int                     COORD_W    = 10,
   parameter int                     COLOR_W    = 8,
   parameter int                     ROM_LAT    = 2,
   parameter int                     SCROLL_W   = 6,
   parameter logic [3*COLOR_W-1:0]   KEY_COLOR  = 24'hFE06FF
) (
   input logic              Clk,
   input logic              Reset_n,
   layer_compositor_if.slave bus
);
   localparam int RGB_W = 3 * COLOR_W;
   localparam int PW    = NUM_LAYERS + 3;
   localparam logic [PW-1:0] PIPE_RST = {{NUM_LAYERS{1'b0}}, 3'b011};

   logic [NUM_LAYERS-1:0]         hit_s0;
   logic [NUM_LAYERS*COORD_W-1:0] ofs_x_s0, ofs_y_s0;

   // Pipe entry: {hit vector, blank, hs, vs}; syncs idle high through reset
   logic [PW-1:0] pipe_q [ROM_LAT+1];
   logic [PW-1:0] pipe_d [ROM_LAT+1];

   logic [NUM_LAYERS*COORD_W-1:0] ofs_x_q, ofs_x_d, ofs_y_q, ofs_y_d;
   logic [RGB_W-1:0]              rgb_q, rgb_d, rgb_sel;
   logic                          blank_out_q, blank_out_d;
   logic                          hs_out_q, hs_out_d, vs_out_q, vs_out_d;
   logic [NUM_LAYERS-1:0]         hit_mask_q, hit_mask_d;
   logic                          frame_collision_q, frame_collision_d;
   logic                          acc_q, acc_d;

   logic [NUM_LAYERS-1:0] out_hit, opaque;
   logic                  out_blank, out_hs, out_vs, collide;

   assign out_hit   = pipe_q[ROM_LAT][PW-1:3];
   assign out_blank = pipe_q[ROM_LAT][2];
   assign out_hs    = pipe_q[ROM_LAT][1];
   assign out_vs    = pipe_q[ROM_LAT][0];

   // Comparisons run one bit wider so scroll and x+w never wrap past the screen edge
   for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_layer
      logic [COORD_W-1:0] lx, ly, lw, lh;
      logic [COORD_W:0]   sx, x_end, y_end;

      assign lx    = bus.layer_x[i*COORD_W +: COORD_W];
      assign ly    = bus.layer_y[i*COORD_W +: COORD_W];
      assign lw    = bus.layer_w[i*COORD_W +: COORD_W];
      assign lh    = bus.layer_h[i*COORD_W +: COORD_W];
      assign sx    = {1'b0, bus.DrawX}
                   + {{(COORD_W+1-SCROLL_W){1'b0}}, bus.layer_scroll[i*SCROLL_W +: SCROLL_W]};
      assign x_end = {1'b0, lx} + {1'b0, lw};
      assign y_end = {1'b0, ly} + {1'b0, lh};

      assign hit_s0[i] = bus.layer_en[i] && (lw != '0) && (lh != '0)
                      && (sx >= {1'b0, lx}) && (sx < x_end)
                      && (bus.DrawY >= ly) && ({1'b0, bus.DrawY} < y_end);

      assign ofs_x_s0[i*COORD_W +: COORD_W] = hit_s0[i] ? (sx[COORD_W-1:0] - lx) : '0;
      assign ofs_y_s0[i*COORD_W +: COORD_W] = hit_s0[i] ? (bus.DrawY - ly) : '0;

      assign opaque[i] = out_hit[i] && (bus.sprite_rgb[i*RGB_W +: RGB_W] != KEY_COLOR);
   end

   // Lowest index wins, so scan from the bottom layer up and let later hits override
   always_comb begin
      rgb_sel = bus.bg_rgb;
      for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
         if (opaque[i]) rgb_sel = bus.sprite_rgb[i*RGB_W +: RGB_W];
      end
   end

   always_comb begin
      pipe_d[0] = {hit_s0, bus.blank, bus.hs_in, bus.vs_in};
      for (int k = 1; k <= ROM_LAT; k++) pipe_d[k] = pipe_q[k-1];
      ofs_x_d           = ofs_x_s0;
      ofs_y_d           = ofs_y_s0;
      blank_out_d       = out_blank;
      hs_out_d          = out_hs;
      vs_out_d          = out_vs;
      rgb_d             = out_blank ? rgb_sel : '0;
      hit_mask_d        = out_blank ? opaque : '0;
      collide           = out_blank && opaque[0] && (|(opaque >> 1));
      acc_d             = acc_q | collide;
      frame_collision_d = frame_collision_q;
      // An overlap on the very pixel where vs falls still belongs to the closing frame
      if (vs_out_q && !out_vs) begin
         frame_collision_d = acc_q | collide;
         acc_d             = 1'b0;
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int k = 0; k <= ROM_LAT; k++) pipe_q[k] <= PIPE_RST;
         ofs_x_q           <= '0;
         ofs_y_q           <= '0;
         rgb_q             <= '0;
         blank_out_q       <= 1'b0;
         hs_out_q          <= 1'b1;
         vs_out_q          <= 1'b1;
         hit_mask_q        <= '0;
         frame_collision_q <= 1'b0;
         acc_q             <= 1'b0;
      end else begin
         for (int k = 0; k <= ROM_LAT; k++) pipe_q[k] <= pipe_d[k];
         ofs_x_q           <= ofs_x_d;
         ofs_y_q           <= ofs_y_d;
         rgb_q             <= rgb_d;
         blank_out_q       <= blank_out_d;
         hs_out_q          <= hs_out_d;
         vs_out_q          <= vs_out_d;
         hit_mask_q        <= hit_mask_d;
         frame_collision_q <= frame_collision_d;
         acc_q             <= acc_d;
      end
   end

   assign bus.ofs_x           = ofs_x_q;
   assign bus.ofs_y           = ofs_y_q;
   assign bus.Red             = rgb_q[RGB_W-1 -: COLOR_W];
   assign bus.Green           = rgb_q[2*COLOR_W-1 -: COLOR_W];
   assign bus.Blue            = rgb_q[COLOR_W-1:0];
   assign bus.blank_out       = blank_out_q;
   assign bus.hs_out          = hs_out_q;
   assign bus.vs_out          = vs_out_q;
   assign bus.hit_mask        = hit_mask_q;
   assign bus.frame_collision = frame_collision_q;
endmodule
